// File: rtl/mem_copy_engine.sv
//------------------------------------------------------------------
// mem_copy_engine: pipelined RAM block copy, writes trail reads by one cycle
// rev 1.0
//------------------------------------------------------------------
`default_nettype none

module mem_copy_engine #(
  parameter int addr_width = 11,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [addr_width-1:0] src_addr,
  input  logic [addr_width-1:0] dst_addr,
  input  logic [addr_width:0]   len,
  output logic                  r_en,
  output logic [addr_width-1:0] r_addr,
  input  logic [data_width-1:0] mem_rdata,
  output logic                  w_en,
  output logic [addr_width-1:0] w_addr,
  output logic [data_width-1:0] w_data,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COPY   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [addr_width-1:0] ADDR_ONE = addr_width'(1);
  localparam logic [addr_width:0]   CNT_ONE  = (addr_width + 1)'(1);

  state_t                state_q, state_d;
  logic [addr_width-1:0] src_q, src_d;
  logic [addr_width-1:0] dst_q, dst_d;
  logic [addr_width:0]   cnt_q, cnt_d;
  logic                  wpend_q, wpend_d;
  logic                  aborted_q, aborted_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      wpend_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      wpend_q   <= wpend_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    wpend_d   = 1'b0;
    aborted_d = aborted_q;
    r_en      = 1'b0;
    w_en      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d     = src_addr;
          dst_d     = dst_addr;
          cnt_d     = len;
          aborted_d = 1'b0;
          state_d   = (len == '0) ? S_FINISH : S_COPY;
        end
      end

      S_COPY: begin
        busy = 1'b1;
        // The write for last cycle's read always lands, even on abort.
        w_en = wpend_q;
        if (wpend_q) dst_d = dst_q + ADDR_ONE;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          r_en    = 1'b1;
          src_d   = src_q + ADDR_ONE;
          cnt_d   = cnt_q - CNT_ONE;
          wpend_d = 1'b1;
          if (cnt_q == CNT_ONE) state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        busy    = 1'b1;
        w_en    = wpend_q;
        dst_d   = dst_q + ADDR_ONE;
        state_d = S_FINISH;
      end

      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign r_addr  = src_q;
  assign w_addr  = dst_q;
  assign w_data  = mem_rdata;
  assign aborted = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_engine.sv
// Directed and randomized bench for mem_copy_engine against a read-first RAM
// and a cycle-level reference model derived from the copy timing rules.
`default_nettype none

module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [10:0] src_addr;
  logic [10:0] dst_addr;
  logic [11:0] len;
  logic        r_en;
  logic [10:0] r_addr;
  logic [7:0]  mem_rdata;
  logic        w_en;
  logic [10:0] w_addr;
  logic [7:0]  w_data;
  logic        busy;
  logic        done;
  logic        aborted;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram  [2048];
  logic [7:0]  snap [2048];
  logic [7:0]  expm [2048];
  logic        reseed  = 1'b0;
  logic        poke_en = 1'b0;
  logic [10:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;

  always #5 clk = ~clk;

  mem_copy_engine #(.addr_width(11), .data_width(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .r_en(r_en), .r_addr(r_addr), .mem_rdata(mem_rdata),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .aborted(aborted)
  );

  // Registered-read RAM; a same-address read and write return the old data.
  always @(posedge clk) begin
    if (reseed) begin
      for (int i = 0; i < 2048; i++) ram[i] <= 8'($urandom);
    end else begin
      if (r_en) mem_rdata <= ram[r_addr];
      if (w_en) ram[w_addr] <= w_data;
      if (poke_en) ram[poke_addr] <= poke_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random();
    @(posedge clk); #1 reseed = 1'b1;
    @(posedge clk); #1 reseed = 1'b0;
  endtask

  task automatic poke(input logic [10:0] a, input logic [7:0] d);
    @(posedge clk); #1 poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); #1 poke_en = 1'b0;
  endtask

  task automatic check_mem(input logic [10:0] s, input logic [10:0] d, input int nw, input string tag);
    int bad;
    logic [10:0] a, b;
    for (int i = 0; i < 2048; i++) expm[i] = snap[i];
    for (int k = 0; k < nw; k++) begin
      a = d + 11'(k);
      b = s + 11'(k);
      expm[a] = snap[b];
    end
    bad = 0;
    for (int i = 0; i < 2048; i++) if (ram[i] !== expm[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // Model: reads in cycles 1..nr, writes in 2..nr+1, done at nr+2 (1 for len 0),
  // where nr is len, or the copy cycle index at which abort was raised.
  task automatic run_copy(input logic [10:0] s, input logic [10:0] d, input logic [11:0] n,
                          input int ab_k, input bit ab_with_start, input bit mid_start);
    int nr, done_c, limit;
    bit ab;
    logic [10:0] a;
    ab     = (ab_k >= 0) && (ab_k < int'(n));
    nr     = ab ? ab_k : int'(n);
    done_c = (n == 0) ? 1 : nr + 2;
    limit  = int'(n) + 4;
    for (int i = 0; i < 2048; i++) snap[i] = ram[i];

    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; len = n; abort = ab_with_start;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_r_en", r_en, 0);

    for (int c = 1; c <= limit && c <= done_c; c++) begin
      @(posedge clk); #1;
      start    = mid_start && (c == 2);
      src_addr = 11'($urandom);
      dst_addr = 11'($urandom);
      len      = 12'($urandom_range(1, 100));
      abort    = (ab_k >= 0) && (c == ab_k + 1);
      #1;
      chk("r_en", r_en, c <= nr);
      chk("w_en", w_en, (c >= 2) && (c <= nr + 1));
      chk("busy", busy, c < done_c);
      chk("done", done, c == done_c);
      if (c <= nr) begin
        a = s + 11'(c - 1);
        chk("r_addr", r_addr, a);
      end
      if ((c >= 2) && (c <= nr + 1)) begin
        a = d + 11'(c - 2);
        chk("w_addr", w_addr, a);
        a = s + 11'(c - 2);
        chk("w_data", w_data, snap[a]);
      end
      if (c == done_c) chk("aborted", aborted, ab);
    end
    start = 1'b0;
    abort = 1'b0;
    @(posedge clk); #2;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("aborted_held", aborted, ab);
    check_mem(s, d, nr, "mem_contents");
  endtask

  initial begin
    logic [10:0] s, d, diff;
    logic [11:0] n;
    int ab_k;
    bit any_act;

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r_en", r_en, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_r_addr", r_addr, 0);
    chk("rst_w_addr", w_addr, 0);
    rst = 1'b1;

    // Basic four-byte copy with known data
    fill_random();
    poke(11'h010, 8'hA1); poke(11'h011, 8'hB2); poke(11'h012, 8'hC3); poke(11'h013, 8'hD4);
    run_copy(11'h010, 11'h400, 12'd4, -1, 1'b0, 1'b0);
    chk("basic_b0", ram[11'h400], 8'hA1);
    chk("basic_b1", ram[11'h401], 8'hB2);
    chk("basic_b2", ram[11'h402], 8'hC3);
    chk("basic_b3", ram[11'h403], 8'hD4);

    run_copy(11'h055, 11'h066, 12'd0, -1, 1'b0, 1'b0);     // zero length
    run_copy(11'h7FE, 11'h002, 12'd4, -1, 1'b0, 1'b0);     // source wraps
    run_copy(11'h100, 11'h300, 12'd8, 3, 1'b0, 1'b0);      // abort in copy cycle 3

    poke(11'h200, 8'h11); poke(11'h201, 8'h22); poke(11'h202, 8'h33); poke(11'h203, 8'h44);
    run_copy(11'h200, 11'h201, 12'd3, -1, 1'b0, 1'b0);    // dst = src + 1
    chk("move_b0", ram[11'h200], 8'h11);
    chk("move_b1", ram[11'h201], 8'h11);
    chk("move_b2", ram[11'h202], 8'h22);
    chk("move_b3", ram[11'h203], 8'h33);

    run_copy(11'h020, 11'h520, 12'd5, 0, 1'b0, 1'b0);      // abort on first copy cycle
    run_copy(11'h030, 11'h530, 12'd5, 5, 1'b0, 1'b0);      // abort in DRAIN
    run_copy(11'h040, 11'h540, 12'd5, 6, 1'b0, 1'b0);      // abort in FINISH
    run_copy(11'h050, 11'h550, 12'd6, -1, 1'b1, 1'b0);     // start and abort together
    run_copy(11'h060, 11'h560, 12'd9, -1, 1'b0, 1'b1);     // start during copy
    run_copy(11'h070, 11'h070, 12'd10, -1, 1'b0, 1'b0);    // dst = src
    run_copy(11'h7F0, 11'h7F1, 12'd2048, -1, 1'b0, 1'b0);  // full memory, dst = src + 1

    // Reset in copy cycle 5 with a start pulse in cycle 3
    fill_random();
    for (int i = 0; i < 2048; i++) snap[i] = ram[i];
    @(posedge clk); #1;
    start = 1'b1; src_addr = 11'h123; dst_addr = 11'h500; len = 12'd16;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start    = (c == 3);
      src_addr = 11'h000;
      dst_addr = 11'h000;
      rst      = (c != 5);
      #1;
      s = 11'h123 + 11'(c - 1);
      chk("rstcase_r_addr", r_addr, s);
    end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    #1;
    chk("rstcase_r_en", r_en, 0);
    chk("rstcase_w_en", w_en, 0);
    chk("rstcase_busy", busy, 0);
    chk("rstcase_done", done, 0);
    chk("rstcase_aborted", aborted, 0);
    chk("rstcase_r_addr0", r_addr, 0);
    chk("rstcase_w_addr0", w_addr, 0);
    any_act = 1'b0;
    repeat (20) begin
      @(posedge clk); #2;
      if (r_en || w_en || done || busy) any_act = 1'b1;
    end
    chk("rstcase_quiet", any_act, 0);
    check_mem(11'h123, 11'h500, 4, "rstcase_mem");

    // Randomized copies, avoiding the overlaps with undefined results
    for (int t = 0; t < 10; t++) begin
      fill_random();
      s = 11'($urandom);
      n = 12'($urandom_range(1, 40));
      do begin
        d    = 11'($urandom);
        diff = d - s;
      end while ((diff >= 11'd2) && ({1'b0, diff} < n));
      ab_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(n) + 1)) : -1;
      run_copy(s, d, n, ab_k, 1'b0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter addr_width, default 11, SHALL set the width of all memory address ports.
REQ-002 Parameter data_width, default 8, SHALL set the width of all memory data ports.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous and active-low.
REQ-005 start  input  1  SHALL request a copy when high in IDLE (one-cycle pulse expected).
REQ-006 abort  input  1  SHALL stop an active copy early.
REQ-007 src_addr  input  addr_width  SHALL give the first source address, sampled with start.
REQ-008 dst_addr  input  addr_width  SHALL give the first destination address, sampled with start.
REQ-009 len  input  addr_width+1  SHALL give the byte count 0..2^addr_width, sampled with start.
REQ-010 r_en, r_addr  output  1, addr_width  SHALL drive the RAM read port (registered read, 1-cycle latency).
REQ-011 mem_rdata  input  data_width  SHALL carry RAM read data, valid the cycle after r_en.
REQ-012 w_en, w_addr, w_data  output  1, addr_width, data_width  SHALL drive the RAM write port.
REQ-013 busy  output  1  SHALL be high while reads or writes are outstanding.
REQ-014 done  output  1  SHALL pulse one cycle on completion or abort.
REQ-015 aborted  output  1  SHALL be high with done when the copy ended by abort; held until next start.

Function
REQ-016 States SHALL be IDLE, COPY, DRAIN, FINISH.
REQ-017 IDLE: start=1 -> latch src/dst/len; len=0 -> FINISH with no memory access; else -> COPY.
REQ-018 COPY: r_en=1, r_addr=src+k at copy cycle k (k=0..len-1), one read per cycle, no stalls.
REQ-019 Writes SHALL trail reads by exactly one cycle: w_en=1, w_addr=dst+k, w_data=mem_rdata (combinational pass-through) in the cycle after read k.
REQ-020 After issuing read len-1, COPY -> DRAIN; DRAIN performs the final write, r_en=0, then -> FINISH.
REQ-021 FINISH: done=1 for one cycle, busy=0, -> IDLE.
REQ-022 Address arithmetic SHALL wrap modulo 2^addr_width (2047+1 -> 0) for source and destination.
REQ-023 busy SHALL be 1 from the first read cycle through the last write cycle; 0 in IDLE and FINISH.
REQ-024 Total latency: start sampled in cycle 0 -> reads cycles 1..len -> writes cycles 2..len+1 -> done in cycle len+2; for len=0, done in cycle 1.
REQ-025 start while not IDLE SHALL be ignored; inputs SHALL not be resampled mid-copy.
REQ-026 abort in COPY: no further reads; a read issued in the abort cycle is not issued (r_en=0 that cycle); the write for the read issued the previous cycle SHALL complete; then FINISH with aborted=1.
REQ-027 abort in DRAIN SHALL not suppress the final write; completion reported with aborted=0.
REQ-028 abort in IDLE or FINISH SHALL be ignored; start and abort together in IDLE: start wins, abort ignored.
REQ-029 Overlap: dst=src or dst=src+1 (mod 2^addr_width) SHALL produce correct memmove results (read precedes same-address write); other overlaps with 2 <= dst-src < len are unspecified.
REQ-030 r_en and w_en SHALL never be high outside COPY/DRAIN.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE and r_en=0, w_en=0, busy=0, done=0, aborted=0, r_addr=0, w_addr=0, regardless of state.
REQ-032 Reset mid-copy SHALL abandon the copy with no further accesses from the next cycle and no done pulse.

Verification
REQ-033 src=0x010, dst=0x400, len=4, RAM[0x10..0x13]=A1,B2,C3,D4 -> reads cycles 1-4, writes cycles 2-5, RAM[0x400..0x403]=A1,B2,C3,D4, done in cycle 6, aborted=0.
REQ-034 len=0 -> no r_en/w_en, done in cycle 1, busy never high.
REQ-035 src=0x7FE, dst=0x002, len=4 -> r_addr sequence 7FE,7FF,000,001; w_addr 002..005.
REQ-036 len=8, abort in copy cycle 3 -> exactly 3 reads and 3 writes (dst..dst+2), done with aborted=1.
REQ-037 dst=src+1, len=3, RAM[src..src+3]=11,22,33,44 -> RAM[src+1..src+3]=11,22,33.
REQ-038 rst=0 during COPY (len=16, cycle 5), start pulsed during copy -> start ignored; after reset all outputs 0, no done, remaining destination bytes untouched.
